// File: rtl/instr_pkg.sv
// Shared RV32I format encoding and request/response types for the instruction
// encoder and the immediate extender.
package instr_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_R = 3'b101;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [2:0]  fmt;
    } enc_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        imm_err;
    } enc_rsp_t;

endpackage

// File: rtl/imm_pack.sv
// Combinational RV32I field packing with immediate range check; an
// unrepresentable immediate or unknown format yields a zero word and imm_err.
module imm_pack
    import instr_pkg::*;
(
    input  enc_req_t req,
    output enc_rsp_t rsp
);

    logic        ok;
    logic [31:0] word;
    logic        hi11_same;
    logic        hi12_same;
    logic        hi20_same;

    // Upper bits all equal means the value sign-extends from the field width.
    assign hi11_same = (&req.imm[31:11]) | ~(|req.imm[31:11]);
    assign hi12_same = (&req.imm[31:12]) | ~(|req.imm[31:12]);
    assign hi20_same = (&req.imm[31:20]) | ~(|req.imm[31:20]);

    always_comb begin
        ok   = 1'b1;
        word = '0;
        case (req.fmt)
            IMM_I: begin
                ok   = hi11_same;
                word = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            end
            IMM_S: begin
                ok   = hi11_same;
                word = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0],
                        req.opcode};
            end
            IMM_B: begin
                ok   = hi12_same && !req.imm[0];
                word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                        req.imm[4:1], req.imm[11], req.opcode};
            end
            IMM_J: begin
                ok   = hi20_same && !req.imm[0];
                word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd,
                        req.opcode};
            end
            IMM_U: begin
                ok   = (req.imm[11:0] == 12'h000);
                word = {req.imm[31:12], req.rd, req.opcode};
            end
            IMM_R: begin
                word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            end
            default: ok = 1'b0;
        endcase
        rsp.instr   = ok ? word : 32'h0000_0000;
        rsp.imm_err = !ok;
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: one output register plus one skid
// register in FIFO order, with saturating delivered/error counters.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       ImmSrc,
    input  logic [6:0]       Opcode,
    input  logic [4:0]       Rd,
    input  logic [4:0]       Rs1,
    input  logic [4:0]       Rs2,
    input  logic [2:0]       Funct3,
    input  logic [6:0]       Funct7,
    input  logic [31:0]      Imm,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      Instr,
    output logic             ImmErr,
    output logic [CNT_W-1:0] EncCount,
    output logic [CNT_W-1:0] ErrCount
);

    enc_req_t req;
    enc_rsp_t rsp;

    assign req.opcode = Opcode;
    assign req.rd     = Rd;
    assign req.rs1    = Rs1;
    assign req.rs2    = Rs2;
    assign req.funct3 = Funct3;
    assign req.funct7 = Funct7;
    assign req.imm    = Imm;
    assign req.fmt    = ImmSrc;

    imm_pack u_imm_pack (
        .req (req),
        .rsp (rsp)
    );

    enc_rsp_t         out_q, out_d;
    enc_rsp_t         skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = InValid && !skid_valid_q;
    assign out_fire = out_valid_q && OutReady;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        enc_cnt_d    = enc_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (!out_valid_q || out_fire) begin
            // Skid can only be full while the output register is full, and then
            // in_fire is blocked, so draining skid never loses a new request.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = rsp;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = rsp;
            skid_valid_d = 1'b1;
        end

        if (out_fire) begin
            if (enc_cnt_q != '1) enc_cnt_d = enc_cnt_q + CNT_W'(1);
            if (out_q.imm_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            enc_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            enc_cnt_q    <= enc_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign InReady  = !skid_valid_q;
    assign OutValid = out_valid_q;
    assign Instr    = out_q.instr;
    assign ImmErr   = out_q.imm_err;
    assign EncCount = enc_cnt_q;
    assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: FIFO/counter model checked every cycle
// plus directed literal vectors, backpressure, reset and saturation runs.
module tb_instr_encoder;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             InValid = 1'b0;
    logic             InReady;
    logic [2:0]       ImmSrc = 3'd0;
    logic [6:0]       Opcode = 7'd0;
    logic [4:0]       Rd = 5'd0;
    logic [4:0]       Rs1 = 5'd0;
    logic [4:0]       Rs2 = 5'd0;
    logic [2:0]       Funct3 = 3'd0;
    logic [6:0]       Funct7 = 7'd0;
    logic [31:0]      Imm = 32'd0;
    logic             OutValid;
    logic             OutReady = 1'b1;
    logic [31:0]      Instr;
    logic             ImmErr;
    logic [CNT_W-1:0] EncCount;
    logic [CNT_W-1:0] ErrCount;

    instr_encoder #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .ImmSrc   (ImmSrc),
        .Opcode   (Opcode),
        .Rd       (Rd),
        .Rs1      (Rs1),
        .Rs2      (Rs2),
        .Funct3   (Funct3),
        .Funct7   (Funct7),
        .Imm      (Imm),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Instr    (Instr),
        .ImmErr   (ImmErr),
        .EncCount (EncCount),
        .ErrCount (ErrCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic [31:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    // Reference encoding from the format rules, range checked arithmetically.
    function automatic exp_t model(input logic [2:0] f, input logic [6:0] op,
                                   input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] imm);
        exp_t        e;
        longint      s;
        bit          ok;
        logic [31:0] w;
        s  = longint'($signed(imm));
        ok = 1'b1;
        w  = 32'd0;
        case (f)
            3'd0: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = {imm[11:0], rs1, f3, rd, op};
            end
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            end
            3'd2: begin
                ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
                w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            end
            3'd3: begin
                ok = (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
                w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            end
            3'd4: begin
                ok = (imm % 4096 == 0);
                w  = {imm[31:12], rd, op};
            end
            3'd5: w = {f7, rs2, rs1, f3, rd, op};
            default: ok = 1'b0;
        endcase
        e.instr = ok ? w : 32'd0;
        e.err   = !ok;
        e.imm   = imm;
        e.fmt   = f;
        return e;
    endfunction

    // Standard RV32I immediate extender, used for the round-trip property.
    function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] f);
        case (f)
            3'd0: return {{20{i[31]}}, i[31:20]};
            3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd4: return {i[31:12], 12'h000};
            default: return 32'd0;
        endcase
    endfunction

    exp_t q[$];
    int   m_enc = 0;
    int   m_err = 0;
    bit   m_in_f;
    bit   m_out_f;

    // Compare at negedge, then advance the model for the coming posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", {31'd0, OutValid}, {31'd0, q.size() > 0});
            check("in_ready", {31'd0, InReady}, {31'd0, q.size() < 2});
            if (q.size() > 0) begin
                check("instr", Instr, q[0].instr);
                check("imm_err", {31'd0, ImmErr}, {31'd0, q[0].err});
                if (!ImmErr && q[0].fmt < 3'd5)
                    check("roundtrip", extend(Instr, q[0].fmt), q[0].imm);
            end
            check("enc_count", {16'd0, EncCount}, m_enc);
            check("err_count", {16'd0, ErrCount}, m_err);
        end
        if (reset) begin
            q.delete();
            m_enc = 0;
            m_err = 0;
        end else begin
            m_in_f  = InValid && (q.size() < 2);
            m_out_f = (q.size() > 0) && OutReady;
            if (m_out_f) begin
                if (m_enc < CNT_MAX) m_enc++;
                if (q[0].err && m_err < CNT_MAX) m_err++;
                void'(q.pop_front());
            end
            if (m_in_f) q.push_back(model(ImmSrc, Opcode, Rd, Rs1, Rs2, Funct3, Funct7, Imm));
        end
    end

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        InValid = 1'b1;
        ImmSrc  = f;
        Opcode  = op;
        Rd      = rd;
        Rs1     = rs1;
        Rs2     = rs2;
        Funct3  = f3;
        Funct7  = f7;
        Imm     = imm;
    endtask

    // Returns #1 after the edge that accepted the currently driven request.
    task automatic wait_accept();
        bit rdy;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rdy = InReady;
            @(posedge clk);
            #1;
            if (rdy) return;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        drive(f, op, rd, rs1, rs2, f3, f7, imm);
        wait_accept();
    endtask

    task automatic idle(input int n);
        InValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [31:0] r;
        logic [31:0] imm;
        logic [2:0]  f;
        int          last;

        // Pin the reference model against hand-computed words.
        e = model(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        check("pin_i", e.instr, 32'hFFF0_0093);
        e = model(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        check("pin_b", e.instr, 32'h0020_8463);
        e = model(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        check("pin_j", e.instr, 32'h0010_00EF);
        e = model(3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);
        check("pin_s", e.instr, 32'hFE20_AE23);
        e = model(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        check("pin_u_err", {31'd0, e.err}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        check("rst_out_valid", {31'd0, OutValid}, 32'd0);
        check("rst_in_ready", {31'd0, InReady}, 32'd1);
        check("rst_instr", Instr, 32'd0);
        check("rst_imm_err", {31'd0, ImmErr}, 32'd0);

        // Directed good vectors.
        OutReady = 1'b1;
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        check("dir_i_valid", {31'd0, OutValid}, 32'd1);
        check("dir_i", Instr, 32'hFFF0_0093);
        check("dir_i_err", {31'd0, ImmErr}, 32'd0);
        send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        check("dir_b", Instr, 32'h0020_8463);
        send(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        check("dir_j", Instr, 32'h0010_00EF);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        check("dir_u", Instr, 32'h1234_52B7);

        // Error vectors.
        send(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        check("err_b", {Instr[30:0], ImmErr}, 32'd1);
        send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        check("err_i", {Instr[30:0], ImmErr}, 32'd1);
        send(3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        check("err_fmt", {Instr[30:0], ImmErr}, 32'd1);
        idle(3);
        check("err_count3", {16'd0, ErrCount}, 32'd3);
        check("enc_count7", {16'd0, EncCount}, 32'd7);

        // Backpressure: two accepts, third waits until the output drains.
        OutReady = 1'b0;
        send(3'd5, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
        send(3'd5, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0);
        drive(3'd5, 7'h33, 5'd7, 5'd8, 5'd9, 3'd7, 7'd0, 32'd0);
        check("bp_in_ready_drop", {31'd0, InReady}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready_hold", {31'd0, InReady}, 32'd0);
        check("bp_hold_instr", Instr, 32'h0031_00B3);
        OutReady = 1'b1;
        wait_accept();
        idle(4);

        // Streaming random requests; accepts must land on consecutive cycles.
        last = 0;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 5));
            r = $urandom;
            case (f)
                3'd0, 3'd1: imm = {{20{r[11]}}, r[11:0]};
                3'd2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
                3'd3:       imm = {{11{r[20]}}, r[20:1], 1'b0};
                3'd4:       imm = {r[31:12], 12'h000};
                default:    imm = r;
            endcase
            if (i % 5 == 4) imm = $urandom;
            send(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), imm);
            if (i > 0) check("stream_gap", cyc - last, 32'd1);
            last = cyc;
        end
        idle(3);

        // Reset with both slots full.
        OutReady = 1'b0;
        send(3'd5, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        send(3'd5, 7'h33, 5'd2, 5'd2, 5'd2, 3'd0, 7'd0, 32'd0);
        InValid = 1'b0;
        check("pre_rst_full", {31'd0, InReady}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_out_valid", {31'd0, OutValid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, InReady}, 32'd1);
        check("mid_rst_enc", {16'd0, EncCount}, 32'd0);
        check("mid_rst_err", {16'd0, ErrCount}, 32'd0);

        // Saturation.
        OutReady = 1'b1;
        drive(3'd5, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'd0, 32'd0);
        repeat ((1 << CNT_W) + 4) @(posedge clk);
        #1;
        idle(2);
        check("sat_enc", {16'd0, EncCount}, 32'h0000_FFFF);
        check("sat_err", {16'd0, ErrCount}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields plus a 32-bit immediate and packs them into a 32-bit instruction word. It is the inverse of the immediate extender and uses the same `ImmSrc` format encoding, so that extending the encoded output returns the original `Imm`. It sits in the self-test/patch path, producing instruction words for the instruction-memory loader, and reports immediates that cannot be represented.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating statistics counters.

Ports:
- `clk`: in, 1. Single clock.
- `reset`: in, 1. Synchronous, active-high.
- `InValid`: in, 1. Request valid.
- `InReady`: out, 1. Encoder can accept a request.
- `ImmSrc`: in, 3. Format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 R; 110 and 111 are invalid.
- `Opcode`: in, 7. Opcode field.
- `Rd`, `Rs1`, `Rs2`: in, 5 each. Register fields.
- `Funct3`: in, 3. Function field.
- `Funct7`: in, 7. Function field, used by R format only.
- `Imm`: in, 32. Full signed immediate, byte offset for B and J.
- `OutValid`: out, 1. Encoded word valid.
- `OutReady`: in, 1. Consumer accepts the encoded word.
- `Instr`: out, 32. Encoded instruction.
- `ImmErr`: out, 1. The immediate was unrepresentable or the format was invalid.
- `EncCount`: out, CNT_W. Words delivered.
- `ErrCount`: out, CNT_W. Words delivered with `ImmErr` set.

## Operation
- Field placement:
  - I: `{Imm[11:0], Rs1, Funct3, Rd, Opcode}`.
  - S: `{Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode}`.
  - B: `{Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Opcode}`.
  - J: `{Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Opcode}`.
  - U: `{Imm[31:12], Rd, Opcode}`.
  - R: `{Funct7, Rs2, Rs1, Funct3, Rd, Opcode}`; `Imm` is ignored.
- Range checks (error if violated):
  - I and S: `Imm[31:11]` all equal.
  - B: `Imm[31:12]` all equal and `Imm[0]`=0.
  - J: `Imm[31:20]` all equal and `Imm[0]`=0.
  - U: `Imm[11:0]`=0.
  - R: never errors.
  - `ImmSrc` 110 or 111 always errors.
- On error: `Instr`=32'h0000_0000 and `ImmErr`=1. The entry still flows through the pipeline and occupies an output slot.
- Buffering: one output register plus one skid register. Order is strictly FIFO.
- Counters:
  - `EncCount` increments on every output handshake (`OutValid && OutReady`).
  - `ErrCount` increments on an output handshake where `ImmErr` is set.
  - Both saturate at all-ones and never wrap.

## Timing
- The input handshake is `InValid && InReady`. The encoded word appears on `OutValid`/`Instr`/`ImmErr` on the next cycle (latency 1). Throughput is 1 word per cycle while `OutReady`=1.
- `InReady` is registered and equals "skid empty". It is never combinationally dependent on `OutReady`.
- Output register full, `OutReady`=0, new request accepted: the new request goes to skid, and `InReady` drops on the following cycle.
- Output pops while skid is full: skid moves to the output register in the same edge, and `InReady` rises the next cycle.
- Output pops and a new request is accepted in the same cycle with skid empty: the new word loads the output register directly, so `OutValid` stays 1.
- `Instr` and `ImmErr` hold stable while `OutValid`=1 and `OutReady`=0.
- Reset values: `OutValid`=0, `InReady`=1, `Instr`=0, `ImmErr`=0, `EncCount`=0, `ErrCount`=0, skid empty.
- Reset asserted mid-stream discards both buffered entries. No handshake completes in a cycle where `reset`=1.

## Structure
- Shared package `instr_pkg`:
  - `ImmSrc` constants `IMM_I`, `IMM_S`, `IMM_B`, `IMM_J`, `IMM_U`, `IMM_R`.
  - Packed struct `enc_req_t` holding opcode, registers, functs, imm and format.
  - Packed struct `enc_rsp_t` holding `Instr` and `ImmErr`.
  - The extender imports the same constants.
- Sub-module `imm_pack`: purely combinational field packing and range check (`enc_req_t` in, `enc_rsp_t` out).
- The top level holds the output register, the skid register, handshake logic and the counters.

## Test plan
- I format, `Opcode`=0x13, `Rd`=1, `Rs1`=0, `Funct3`=0, `Imm`=0xFFFFFFFF → `Instr`=0xFFF00093, `ImmErr`=0, one cycle after accept.
- B format, `Opcode`=0x63, `Rs1`=1, `Rs2`=2, `Imm`=8 → 0x00208463. J format, `Opcode`=0x6F, `Rd`=1, `Imm`=0x800 → 0x001000EF. U format, `Opcode`=0x37, `Rd`=5, `Imm`=0x12345000 → 0x123452B7.
- Error cases, each → `Instr`=0 and `ImmErr`=1, after which `ErrCount`=3:
  - B with `Imm`=3.
  - I with `Imm`=0x800.
  - `ImmSrc`=111.
- Backpressure: hold `OutReady`=0 with `InValid`=1 and three distinct requests.
  - Exactly 2 are accepted; `InReady`=0 from the cycle after the second accept.
  - Release `OutReady`: words emerge in order, and the third request is accepted.
- Streaming: `OutReady`=1 with back-to-back requests → one word per cycle, `OutValid` continuously 1. Random requests must round-trip: extend(`Instr`, `ImmSrc`) == `Imm` whenever `ImmErr`=0.
- Reset and saturation:
  - Assert `reset` with both slots full → next cycle `OutValid`=0, `InReady`=1, counters 0.
  - Force 2^CNT_W+2 handshakes → `EncCount` holds at 0xFFFF.
